// File: rtl/multiplier_control.sv
// -----------------------------------------------------------------------------
// multiplier_control
//
// Sequencing FSM for a shift-add multiplier datapath. It sits directly
// upstream of the Product register. The multiplicand register and the ALU
// share its enables.
//
// One multiply runs as follows:
//   IDLE -> LOAD -> ITER (exactly WIDTH cycles) -> DONE
//   - LOAD: Product captures the multiplier on its falling edge.
//   - ITER: each cycle Product optionally adds the multiplicand to its upper
//     half and then shifts right.
//   - DONE: terminal. The Product register cannot reload without its own
//     reset, so only rst leaves DONE.
//
// Handshake: this block has no valid/ready pair in the usual sense.
//   - ready=0 means Product is loading or iterating this cycle.
//   - ready=1 means Product holds its value.
//   - start is a level request and is sampled only in IDLE.
//   - A start seen in LOAD, ITER or DONE is ignored.
//
// Parameters
//   WIDTH  operand width, and also the number of add/shift iterations
//   CNT_W  iteration counter width; 2**CNT_W must exceed WIDTH
//
// Ports
//   clk          in   system clock; the FSM updates on the rising edge
//   rst          in   asynchronous, active-low reset
//   start        in   multiply request
//   product_lsb  in   Product_out[0], fed back from Product
//   SRL_ctrl     out  1 = Product performs one iteration this cycle
//   w_ctrl       out  1 = Product writes the ALU result before shifting
//   ready        out  0 = Product loads/iterates; 1 = Product holds
//   busy         out  1 while in LOAD or ITER
//   done         out  one-cycle pulse on entry to DONE
//
// Optional debug (macro MULT_CTRL_DBG_EN)
//   When the macro is defined, two extra outputs appear:
//     dbg_iter   [CNT_W-1:0]  current iteration count
//     dbg_state  [1:0]        IDLE=0, LOAD=1, ITER=2, DONE=3
//   When the macro is undefined, these ports are absent. The function of
//   all other ports is identical in both builds.
// -----------------------------------------------------------------------------
module multiplier_control #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic product_lsb,
    output logic SRL_ctrl,
    output logic w_ctrl,
    output logic ready,
    output logic busy,
    output logic done
`ifdef MULT_CTRL_DBG_EN
    ,
    output logic [CNT_W-1:0] dbg_iter,
    output logic [1:0]       dbg_state
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
    logic             done_q, done_d;
    logic             srl_int;

    // State register, iteration counter and done pulse flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            iter_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        state_d    = state_q;
        iter_cnt_d = iter_cnt_q;
        srl_int    = 1'b0;
        ready      = 1'b1;
        busy       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                ready      = 1'b0;
                busy       = 1'b1;
                iter_cnt_d = '0;
                state_d    = S_ITER;
            end

            S_ITER: begin
                ready   = 1'b0;
                busy    = 1'b1;
                srl_int = 1'b1;
                // The counter freezes at the last iteration, so it never
                // wraps. DONE holds it there until reset.
                if (iter_cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                end else begin
                    iter_cnt_d = iter_cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                // Terminal state: start is ignored here.
                state_d = S_DONE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Set only on the edge that enters DONE, so the pulse lasts one cycle.
        done_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    assign SRL_ctrl = srl_int;
    assign done     = done_q;

    // product_lsb is gated combinationally, not registered. Product updates
    // product_lsb on the falling edge, and w_ctrl must reflect the new value
    // before Product's next falling edge.
    assign w_ctrl = srl_int & product_lsb;

`ifdef MULT_CTRL_DBG_EN
    assign dbg_iter  = iter_cnt_q;
    assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_multiplier_control.sv
// -----------------------------------------------------------------------------
// tb_multiplier_control
//
// Bench for multiplier_control with a behavioural Product/ALU datapath model.
//
// Product model:
//   - Updates on the falling edge.
//   - Loads the multiplier when ready=0 and SRL_ctrl=0.
//   - When SRL_ctrl=1 it adds the multiplicand to its upper half if w_ctrl=1,
//     then shifts the full 65-bit sum right by one.
//
// Checking flow:
//   - Stimulus pushes three kinds of expectation into queues:
//       * the expected 64-bit product,
//       * the expected w_ctrl value for each iteration,
//       * the expected LOAD-to-done latency.
//   - A monitor samples 1 ns after each rising edge and pops/compares them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_multiplier_control;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    // Clock / reset
    logic clk;
    logic rst;
    logic start;
    logic product_lsb;
    logic SRL_ctrl;
    logic w_ctrl;
    logic ready;
    logic busy;
    logic done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multiplier_control #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .product_lsb(product_lsb),
        .SRL_ctrl   (SRL_ctrl),
        .w_ctrl     (w_ctrl),
        .ready      (ready),
        .busy       (busy),
        .done       (done)
    );

    // Product + ALU datapath model
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [63:0] prod;
    logic [32:0] alu_sum;

    assign product_lsb = prod[0];
    assign alu_sum     = {1'b0, prod[63:32]} + {1'b0, mcand};

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            prod <= '0;
        end else if (!ready && !SRL_ctrl) begin
            prod <= {32'd0, mplier};
        end else if (SRL_ctrl) begin
            if (w_ctrl) prod <= {alu_sum, prod[31:1]};
            else        prod <= {1'b0, prod[63:1]};
        end
    end

    // Scoreboard state
    logic [63:0] exp_q[$];
    logic [0:0]  exp_w_q[$];
    logic [7:0]  lat_q[$];
    int n_cmp;
    int n_err;
    int done_cnt;
    int srl_cnt;
    int lat;
    logic prev_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    initial begin
        srl_cnt   = 0;
        lat       = 0;
        prev_done = 1'b0;
        done_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                srl_cnt   = 0;
                lat       = 0;
                prev_done = 1'b0;
            end else begin
                if (busy && !SRL_ctrl) begin
                    lat     = 0;
                    srl_cnt = 0;
                end else begin
                    lat++;
                end

                if (SRL_ctrl) begin
                    srl_cnt++;
                    if (exp_w_q.size() > 0) begin
                        chk("w_ctrl_iter", {63'd0, w_ctrl}, {63'd0, exp_w_q.pop_front()});
                    end else begin
                        chk("srl_unexpected", {63'd0, SRL_ctrl}, 64'd0);
                    end
                end else begin
                    chk("w_ctrl_idle", {63'd0, w_ctrl}, 64'd0);
                end

                if (prev_done) begin
                    chk("done_one_cycle", {63'd0, done}, 64'd0);
                end

                if (done) begin
                    done_cnt++;
                    if (exp_q.size() > 0) begin
                        chk("product", prod, exp_q.pop_front());
                        chk("srl_count", 64'(srl_cnt), 64'(WIDTH));
                        chk("done_latency", 64'(lat), {56'd0, lat_q.pop_front()});
                        chk("ready_at_done", {63'd0, ready}, 64'd1);
                    end else begin
                        chk("done_unexpected", {63'd0, done}, 64'd0);
                    end
                end

                prev_done = done;
            end
        end
    end

    // Driver tasks

    // Asserts reset midway between edges and checks the idle outputs
    // before any clock edge can occur.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_ready", {63'd0, ready},    64'd1);
        chk("rst_srl",   {63'd0, SRL_ctrl}, 64'd0);
        chk("rst_w",     {63'd0, w_ctrl},   64'd0);
        chk("rst_busy",  {63'd0, busy},     64'd0);
        chk("rst_done",  {63'd0, done},     64'd0);
        exp_q.delete();
        exp_w_q.delete();
        lat_q.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Queues the expectations for one multiply, then issues start. Expected
    // values are hand-computed constants passed in by the caller.
    task automatic issue(input logic [31:0] mc, input logic [31:0] mp, input logic [63:0] exp_p);
        mcand  = mc;
        mplier = mp;
        exp_q.push_back(exp_p);
        for (int i = 0; i < WIDTH; i++) exp_w_q.push_back(mp[i]);
        // One LOAD cycle plus WIDTH ITER cycles separate LOAD from done.
        lat_q.push_back(8'd33);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int k = 0; k < 100 && done_cnt == d0; k++) @(negedge clk);
        chk("done_timeout", 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic run_mult(input logic [31:0] mc, input logic [31:0] mp,
                            input logic [63:0] exp_p, input bit retrig);
        int d0;
        d0 = done_cnt;
        issue(mc, mp, exp_p);
        if (retrig) begin
            repeat (10) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(d0);
        if (retrig) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("done_once",   64'(done_cnt), 64'(d0 + 1));
        chk("after_ready", {63'd0, ready}, 64'd1);
        chk("after_busy",  {63'd0, busy},  64'd0);
        chk("after_srl",   {63'd0, SRL_ctrl}, 64'd0);
        chk("after_prod",  prod, exp_p);
    endtask

    // Main sequence
    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b0;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        @(negedge clk);
        rst = 1'b1;
        do_reset();

        // Idle hold: no start for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready", {63'd0, ready},    64'd1);
            chk("idle_srl",   {63'd0, SRL_ctrl}, 64'd0);
            chk("idle_busy",  {63'd0, busy},     64'd0);
        end

        // 7 x 9 = 63.
        run_mult(32'd7, 32'd9, 64'd63, 1'b0);

        // w_ctrl tracks multiplier bits 0,2,5,7,...; 1 x 0xA5A5A5A5.
        do_reset();
        run_mult(32'd1, 32'hA5A5A5A5, 64'h00000000A5A5A5A5, 1'b0);

        // Full-range operands, with start retriggered in ITER and in DONE.
        do_reset();
        run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b1);

        // Start held high for the whole run has no effect.
        do_reset();
        mcand  = 32'd6;
        mplier = 32'd11;
        exp_q.push_back(64'd66);
        for (int i = 0; i < WIDTH; i++) exp_w_q.push_back(mplier[i]);
        lat_q.push_back(8'd33);
        begin
            int d0;
            d0 = done_cnt;
            @(negedge clk);
            start = 1'b1;
            wait_done(d0);
            repeat (4) @(negedge clk);
            chk("held_done_once", 64'(done_cnt), 64'(d0 + 1));
            chk("held_busy", {63'd0, busy}, 64'd0);
            start = 1'b0;
        end

        // Reset asserted at iteration 15, then a clean 3 x 5 run.
        do_reset();
        issue(32'd7, 32'd9, 64'd63);
        for (int k = 0; k < 100 && srl_cnt < 15; k++) @(negedge clk);
        chk("reach_iter15", 64'(srl_cnt), 64'd15);
        chk("mid_busy", {63'd0, busy}, 64'd1);
        do_reset();
        run_mult(32'd3, 32'd5, 64'd15, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
